conv_pe_pipe: RTL and testbench

//  Parametrised, pipelined KxK convolution processing element with valid/ready flow control.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_pe_pipe_if.sv | 32 +++
 rtl/conv_adder_tree.sv | 30 +++
 rtl/conv_pe_pipe.sv | 122 ++++++++++++
 tb/tb_conv_pe_pipe.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry constants, data type and fixed-point multiply for
// the conv_pe_pipe convolution processing element.
package conv_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 16;
  localparam int KNL_DIM    = 5;
  localparam int KNL_SIZE   = KNL_DIM * KNL_DIM;
  localparam int KNL_NUM    = 16;
  localparam int BANK_SIZE  = KNL_NUM * KNL_SIZE;
  localparam int BANK_AW    = $clog2(BANK_SIZE);
  localparam int SEL_W      = $clog2(KNL_NUM);
  localparam int NUMK_W     = SEL_W + 1;
  localparam int ACC_W      = DATA_WIDTH + $clog2(KNL_SIZE) + 1;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  // Full-width signed product, then the slice equals (p >>> FRAC_BITS) truncated.
  function automatic data_t fx_mul(input data_t a, input data_t b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return p[FRAC_BITS +: DATA_WIDTH];
  endfunction
endpackage

// File: rtl/conv_pe_pipe_if.sv
// conv_pe_pipe_if: load, op-request and result signals between the layer
// controller (master) and the convolution PE (slave).
interface conv_pe_pipe_if;
  import conv_pkg::*;

  logic              knl_wr_en;
  data_t             knl_wr_data;
  logic              win_wr_en;
  data_t             win_wr_data;
  logic [NUMK_W-1:0] num_knls;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  knl_sel;
  logic              acc_en;
  data_t             psum_in;
  logic              out_valid;
  logic              out_ready;
  data_t             out_data;
  logic              sel_err;

  modport master (
    output knl_wr_en, knl_wr_data, win_wr_en, win_wr_data, num_knls,
           in_valid, knl_sel, acc_en, psum_in, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

  modport slave (
    input  knl_wr_en, knl_wr_data, win_wr_en, win_wr_data, num_knls,
           in_valid, knl_sel, acc_en, psum_in, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
endinterface

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: registered N_IN-input signed sum, sign-extending each input
// to OUT_W; synthesis rebalances the linear sum into a tree.
module conv_adder_tree #(
  parameter int N_IN  = 26,
  parameter int IN_W  = 32,
  parameter int OUT_W = 38
) (
  input  logic                        clk,
  input  logic                        i_en,
  input  logic [N_IN-1:0][IN_W-1:0]   i_data,
  output logic signed [OUT_W-1:0]     o_sum
);

  logic signed [OUT_W-1:0] w_sum;

  // NOTE: blocking '=' here is intentional -- each loop step must see the
  // previous partial sum within the same evaluation.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_sum = w_sum + OUT_W'($signed(i_data[i]));
    end
  end

  // NOTE: clocked state uses '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_en) o_sum <= w_sum;
  end

endmodule

// File: rtl/conv_pe_pipe.sv
// conv_pe_pipe: 3-stage KxK fixed-point convolution PE (S1 multiply, S2 sum,
// S3 output). Define CONV_PE_SAT_EN to saturate results instead of wrapping.
module conv_pe_pipe
  import conv_pkg::*;
(
  input  logic           clk,
  input  logic           srstn,
  conv_pe_pipe_if.slave  bus
);

  logic [BANK_SIZE-1:0][DATA_WIDTH-1:0] r_bank;
  logic [KNL_SIZE-1:0][DATA_WIDTH-1:0]  r_win;

  // NOTE: the kernel bank and window are storage, not control state; they are
  // deliberately left out of reset and only change on a write strobe.
  always_ff @(posedge clk) begin
    if (bus.knl_wr_en) r_bank <= {bus.knl_wr_data, r_bank[BANK_SIZE-1:1]};
    if (bus.win_wr_en) r_win  <= {bus.win_wr_data, r_win[KNL_SIZE-1:1]};
  end

  logic               w_adv;
  logic               w_accept;
  logic [NUMK_W-1:0]  w_nk;
  logic               w_err;
  logic [BANK_AW-1:0] w_base;

  // A full output register that is not being drained freezes the whole pipe.
  assign w_adv        = !(bus.out_valid && !bus.out_ready);
  assign w_accept     = bus.in_valid && w_adv;
  assign bus.in_ready = w_adv;

  // NOTE: every output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    w_nk   = bus.num_knls;
    w_base = '0;
    if (bus.num_knls > NUMK_W'(KNL_NUM)) w_nk = NUMK_W'(KNL_NUM);
    w_err = NUMK_W'(bus.knl_sel) >= w_nk;
    if (!w_err) begin
      w_base = BANK_AW'((KNL_NUM - int'(w_nk) + int'(bus.knl_sel)) * KNL_SIZE);
    end
  end

  // Operand set for S2: KNL_SIZE products plus the optional partial sum.
  logic [KNL_SIZE:0][DATA_WIDTH-1:0] w_ops;

  for (genvar r = 0; r < KNL_DIM; r++) begin : g_row
    for (genvar c = 0; c < KNL_DIM; c++) begin : g_col
      assign w_ops[r*KNL_DIM+c] = w_err ? '0 :
        fx_mul(r_bank[w_base + BANK_AW'(r*KNL_DIM+c)], r_win[c*KNL_DIM+r]);
    end
  end
  assign w_ops[KNL_SIZE] = bus.acc_en ? bus.psum_in : '0;

  logic                              r_s1_valid;
  logic                              r_s1_err;
  logic [KNL_SIZE:0][DATA_WIDTH-1:0] r_s1_ops;
  logic                              r_s2_valid;
  logic                              r_s2_err;
  logic signed [ACC_W-1:0]           w_s2_sum;
  data_t                             w_res;
  logic                              r_out_valid;
  data_t                             r_out_data;
  logic                              r_sel_err;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_ops <= w_ops;
      r_s1_err <= w_err;
    end
    if (w_adv && r_s1_valid) r_s2_err <= r_s1_err;
  end

  conv_adder_tree #(
    .N_IN  (KNL_SIZE + 1),
    .IN_W  (DATA_WIDTH),
    .OUT_W (ACC_W)
  ) u_adder_tree (
    .clk    (clk),
    .i_en   (w_adv && r_s1_valid),
    .i_data (r_s1_ops),
    .o_sum  (w_s2_sum)
  );

`ifdef CONV_PE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    w_res = w_s2_sum[DATA_WIDTH-1:0];
    if (w_s2_sum > SAT_MAX)      w_res = SAT_MAX[DATA_WIDTH-1:0];
    else if (w_s2_sum < SAT_MIN) w_res = SAT_MIN[DATA_WIDTH-1:0];
  end
`else
  assign w_res = w_s2_sum[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel_err   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= bus.in_valid;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= w_res;
        r_sel_err  <= r_s2_err;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_conv_pe_pipe.sv
// tb_conv_pe_pipe: directed cases with literal results plus randomized traffic
// checked every cycle against an arithmetic model of the PE.
module tb_conv_pe_pipe;
  import conv_pkg::*;

  logic clk;
  logic srstn;
  int   n_checks = 0;
  int   n_err    = 0;

  conv_pe_pipe_if bus ();

  conv_pe_pipe dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int bank_m [BANK_SIZE];
  int win_m  [KNL_SIZE];

  function automatic logic [31:0] model_op(input int sel, input int nk_raw,
                                           input bit acc, input int psum,
                                           output bit err);
    int     nk;
    int     base;
    longint p;
    longint sum;
    nk  = (nk_raw > KNL_NUM) ? KNL_NUM : nk_raw;
    err = (sel >= nk);
    sum = 0;
    if (!err) begin
      base = (KNL_NUM - nk + sel) * KNL_SIZE;
      for (int r = 0; r < KNL_DIM; r++) begin
        for (int c = 0; c < KNL_DIM; c++) begin
          p   = longint'(bank_m[base + r*KNL_DIM + c]) * longint'(win_m[c*KNL_DIM + r]);
          sum = sum + longint'(int'(p >>> FRAC_BITS));
        end
      end
    end
    if (acc) sum = sum + longint'(psum);
`ifdef CONV_PE_SAT_EN
    if (sum > 64'sd2147483647)       sum = 64'sd2147483647;
    else if (sum < -64'sd2147483648) sum = -64'sd2147483648;
`endif
    return sum[31:0];
  endfunction

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   stall_cnt = 0;

  // Compare process: one pass per cycle, mid-cycle, when all signals are stable.
  always @(negedge clk) begin
    logic        exp_v;
    logic        exp_rdy;
    bit          e;
    logic [31:0] d;
    cyc++;
    if (!srstn) begin
      q.delete();
    end else begin
      exp_v = 1'b0;
      if (q.size() != 0)
        exp_v = (cyc >= q[0].acc_cyc + 3 + (stall_cnt - q[0].acc_stall));
      check("out_valid", 32'(bus.out_valid), 32'(exp_v));
      if (exp_v && bus.out_valid) begin
        check("out_data", bus.out_data, q[0].data);
        check("sel_err", 32'(bus.sel_err), 32'(q[0].err));
      end
      exp_rdy = !(exp_v && !bus.out_ready);
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (exp_v && bus.out_ready) void'(q.pop_front());
      if (exp_v && !bus.out_ready) stall_cnt++;
      if (bus.in_valid && exp_rdy) begin
        d = model_op(int'(bus.knl_sel), int'(bus.num_knls), bus.acc_en, int'(bus.psum_in), e);
        q.push_back('{data: d, err: e, acc_cyc: cyc, acc_stall: stall_cnt});
      end
    end
    // Loads take effect after any same-cycle op has sampled the old contents.
    if (bus.knl_wr_en) begin
      for (int i = 0; i < BANK_SIZE-1; i++) bank_m[i] = bank_m[i+1];
      bank_m[BANK_SIZE-1] = int'(bus.knl_wr_data);
    end
    if (bus.win_wr_en) begin
      for (int i = 0; i < KNL_SIZE-1; i++) win_m[i] = win_m[i+1];
      win_m[KNL_SIZE-1] = int'(bus.win_wr_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_knl(input data_t d);
    bus.knl_wr_en   = 1'b1;
    bus.knl_wr_data = d;
    tick();
    bus.knl_wr_en   = 1'b0;
  endtask

  task automatic load_win(input data_t d);
    bus.win_wr_en   = 1'b1;
    bus.win_wr_data = d;
    tick();
    bus.win_wr_en   = 1'b0;
  endtask

  task automatic op(input int sel, input bit acc, input data_t psum);
    bus.in_valid = 1'b1;
    bus.knl_sel  = SEL_W'(sel);
    bus.acc_en   = acc;
    bus.psum_in  = psum;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid and checks data, error flag and latency.
  task automatic wait_out(input logic [31:0] exp_d, input bit exp_e, input int exp_lat,
                          input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 12);
    check({name, " latency"}, 32'(k), 32'(exp_lat));
    check({name, " data"}, bus.out_data, exp_d);
    check({name, " sel_err"}, 32'(bus.sel_err), 32'(exp_e));
    tick();
  endtask

  initial begin
    logic [31:0] md;
    bit          me;

    srstn           = 1'b0;
    bus.knl_wr_en   = 1'b0;
    bus.knl_wr_data = '0;
    bus.win_wr_en   = 1'b0;
    bus.win_wr_data = '0;
    bus.num_knls    = NUMK_W'(1);
    bus.in_valid    = 1'b0;
    bus.knl_sel     = '0;
    bus.acc_en      = 1'b0;
    bus.psum_in     = '0;
    bus.out_ready   = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data", bus.out_data, 32'd0);
    check("rst sel_err", 32'(bus.sel_err), 32'd0);
    tick();
    srstn = 1'b1;
    tick();

    // 1: all-1.0 kernel over window 1..25
    repeat (KNL_SIZE) load_knl(32'h0001_0000);
    for (int i = 1; i <= KNL_SIZE; i++) load_win(data_t'(i << 16));
    md = model_op(0, 1, 1'b0, 0, me);
    check("t1 model", md, 32'h0145_0000);
    op(0, 1'b0, '0);
    wait_out(32'h0145_0000, 1'b0, 3, "t1");

    // 2: accumulate psum, then stall the output for 4 cycles
    bus.out_ready = 1'b0;
    op(0, 1'b1, 32'h0005_0000);
    wait_out(32'h014A_0000, 1'b0, 3, "t2");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2 hold valid", 32'(bus.out_valid), 32'd1);
      check("t2 hold data", bus.out_data, 32'h014A_0000);
      check("t2 hold in_ready", 32'(bus.in_ready), 32'd0);
    end
    tick();
    bus.out_ready = 1'b1;
    tick();

    // 3: two kernels (2.0 oldest, -1.0 newest), back-to-back ops
    bus.num_knls = NUMK_W'(2);
    repeat (KNL_SIZE) load_knl(32'h0002_0000);
    repeat (KNL_SIZE) load_knl(32'hFFFF_0000);
    repeat (KNL_SIZE) load_win(32'h0001_0000);
    md = model_op(1, 2, 1'b0, 0, me);
    check("t3 model", md, 32'hFFE7_0000);
    bus.in_valid = 1'b1;
    bus.acc_en   = 1'b0;
    bus.knl_sel  = SEL_W'(1);
    tick();
    bus.knl_sel  = SEL_W'(0);
    tick();
    bus.in_valid = 1'b0;
    wait_out(32'hFFE7_0000, 1'b0, 2, "t3 first");
    @(negedge clk);
    check("t3 second valid", 32'(bus.out_valid), 32'd1);
    check("t3 second data", bus.out_data, 32'h0032_0000);
    tick();

    // 4: out-of-range kernel select returns psum and flags the error
    op(3, 1'b1, 32'd7);
    wait_out(32'd7, 1'b1, 3, "t4");

    // 5: op in the same cycle as a window shift sees the old window
    bus.win_wr_en   = 1'b1;
    bus.win_wr_data = 32'h0003_0000;
    op(0, 1'b0, '0);
    bus.win_wr_en   = 1'b0;
    wait_out(32'h0032_0000, 1'b0, 3, "t5 old");
    op(0, 1'b0, '0);
    wait_out(32'h0036_0000, 1'b0, 3, "t5 new");

    // 6: per-product truncation, then accumulator overflow
    bus.num_knls = NUMK_W'(1);
    repeat (KNL_SIZE) load_knl(32'h7FFF_0000);
    repeat (KNL_SIZE) load_win(32'h7FFF_0000);
    op(0, 1'b0, '0);
    wait_out(32'h0019_0000, 1'b0, 3, "t6 trunc");
    repeat (KNL_SIZE) load_win(32'h0001_0000);
    op(0, 1'b0, '0);
`ifdef CONV_PE_SAT_EN
    wait_out(32'h7FFF_FFFF, 1'b0, 3, "t6 overflow");
`else
    wait_out(32'h7FE7_0000, 1'b0, 3, "t6 overflow");
`endif

    // Reset while three ops are in flight
    bus.in_valid = 1'b1;
    bus.knl_sel  = '0;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    srstn        = 1'b0;
    tick();
    @(negedge clk);
    check("rst mid out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    srstn = 1'b1;
    repeat (5) tick();

    // Randomized traffic over a fully loaded bank
    repeat (BANK_SIZE) load_knl($urandom);
    repeat (KNL_SIZE) load_win($urandom);
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.knl_sel     = SEL_W'($urandom_range(0, KNL_NUM-1));
      bus.num_knls    = NUMK_W'($urandom_range(0, 20));
      bus.acc_en      = 1'($urandom_range(0, 1));
      bus.psum_in     = $urandom;
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.knl_wr_en   = ($urandom_range(0, 7) == 0);
      bus.knl_wr_data = $urandom;
      bus.win_wr_en   = ($urandom_range(0, 4) == 0);
      bus.win_wr_data = $urandom;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.knl_wr_en = 1'b0;
    bus.win_wr_en = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("drain queue empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
